// File: rtl/coherence_memory_ctrl.sv
// coherence_memory_ctrl: memory-side snooping coherence responder with per-line state, owner tracking and backing storage
//   clk, rst_n                      : clock, asynchronous active-low reset
//   req_valid/req_ready             : request bus handshake (req_source, req_addr, req_bus_tx)
//   wb_valid, wb_addr, wb_data      : owner writeback to memory, sampled every cycle
//   resp_valid/resp_ready           : response handshake (resp_destination, resp_addr, resp_data, resp_mmsg)
module coherence_memory_ctrl #(
  parameter int NUM_LINES      = 16,
  parameter int NUM_CACHE      = 8,
  parameter int XLEN           = 32,
  parameter int CACHELINE_SIZE = 8,
  parameter int MEM_LATENCY    = 2,
  localparam int IDX_W         = $clog2(NUM_LINES),
  localparam int SRC_W         = $clog2(NUM_CACHE) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [SRC_W-1:0]          req_source,
  input  logic [XLEN-1:0]           req_addr,
  input  logic [1:0]                req_bus_tx,
  input  logic                      wb_valid,
  input  logic [XLEN-1:0]           wb_addr,
  input  logic [CACHELINE_SIZE-1:0] wb_data,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [SRC_W-1:0]          resp_destination,
  output logic [XLEN-1:0]           resp_addr,
  output logic [CACHELINE_SIZE-1:0] resp_data,
  output logic [1:0]                resp_mmsg
);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [1:0] GETS = 2'd0, GETM = 2'd1, PUTM = 2'd2, IDLE_TX = 2'd3;
  localparam logic [1:0] EXCLUSIVE = 2'd0, DATA = 2'd1, NODATA = 2'd2;
  typedef enum logic [2:0] {MI, MS, MEORM, MSD, MID, MEORMD} memory_state_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} fsm_t;
  fsm_t fsm;
  memory_state_t line_state [NUM_LINES];
  logic [SRC_W-1:0] owner [NUM_LINES];
  logic [CACHELINE_SIZE-1:0] mem [NUM_LINES];
  logic [CNT_W-1:0] cnt;
  logic alive;
  logic [IDX_W-1:0] idx, wb_idx;
  memory_state_t cur, nxt, wb_cur, wb_nxt;
  logic accept, respond, set_owner, wb_hit;
  logic [1:0] act_mmsg;
  logic unused;
  assign unused = ^{req_addr[XLEN-1:IDX_W], wb_addr[XLEN-1:IDX_W]};
  assign idx = req_addr[IDX_W-1:0];
  assign wb_idx = wb_addr[IDX_W-1:0];
  assign cur = line_state[idx];
  assign wb_cur = line_state[wb_idx];
  // alive is a flop so req_ready is held low for the whole reset window
  assign req_ready = alive && fsm == S_IDLE && !(cur inside {MSD, MID, MEORMD});
  assign accept = req_valid && req_ready && req_bus_tx != IDLE_TX;
  assign wb_hit = wb_valid && (wb_cur inside {MSD, MID, MEORMD});
  assign wb_nxt = wb_cur == MSD ? MS : wb_cur == MID ? MI : MEORM;
  always_comb begin
    respond = 1'b0;
    act_mmsg = NODATA;
    nxt = cur;
    set_owner = 1'b0;
    case (req_bus_tx)
      GETS: begin
        respond = cur == MI || cur == MS;
        act_mmsg = cur == MI ? EXCLUSIVE : DATA;
        set_owner = cur == MI;
        nxt = cur == MI ? MEORM : cur == MEORM ? MSD : cur;
      end
      GETM: begin
        respond = cur == MI || cur == MS;
        act_mmsg = DATA;
        set_owner = cur == MI || cur == MS || cur == MEORM;
        nxt = cur == MI || cur == MS ? MEORM : cur;
      end
      PUTM: begin
        // only the recorded owner of an exclusive line can hand it back; everyone else just gets an ack
        respond = !(cur == MEORM && req_source == owner[idx]);
        nxt = respond ? cur : MID;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= S_IDLE;
      cnt <= '0;
      alive <= 1'b0;
      resp_valid <= 1'b0;
      resp_destination <= '0;
      resp_addr <= '0;
      resp_data <= '0;
      resp_mmsg <= NODATA;
      for (int i = 0; i < NUM_LINES; i++) begin
        line_state[i] <= MI;
        owner[i] <= '0;
        mem[i] <= '0;
      end
    end else begin
      alive <= 1'b1;
      if (wb_hit) begin
        line_state[wb_idx] <= wb_nxt;
        mem[wb_idx] <= wb_data;
      end
      case (fsm)
        S_IDLE: if (accept) begin
          line_state[idx] <= nxt;
          if (set_owner) owner[idx] <= req_source;
          if (respond) begin
            resp_destination <= req_source;
            resp_addr <= req_addr;
            resp_mmsg <= act_mmsg;
            resp_data <= act_mmsg == NODATA ? '0 : mem[idx];
            cnt <= CNT_W'(MEM_LATENCY);
            fsm <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            fsm <= S_SEND;
            resp_valid <= 1'b1;
          end
        end
        S_SEND: if (resp_ready) begin
          resp_valid <= 1'b0;
          fsm <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end
endmodule
